motcomp_recon_add: RTL and testbench
====================================

# motcomp_recon_add

Reconstruction adder directly downstream of the dct-type converter in the motion compensation path. Per 8x8 block it reads eight frame-ordered idct rows (8 x 9-bit signed) and, depending on a per-block command, eight prediction rows (8 x 8-bit unsigned). It adds them, clips each sample to 0..255 and writes eight 64-bit pixel rows to the reconstruction writer. Block commands come from a small command fifo that the motion compensation sequencer fills in the same block order as the idct stream.

## Interface
Parameters: none; command codes RECON_INTRA=2'd0, RECON_ADD=2'd1, RECON_PRED_ONLY=2'd2 (2'd3 reserved).
- clk  input  1  clock, rising edge
- clk_en  input  1  clock enable; all state frozen when low
- rst  input  1  reset, synchronous, active low
- recon_cmd_empty  input  1  command fifo empty
- recon_cmd  input  2  block command, sampled when recon_cmd_valid
- recon_cmd_en  output  1  command fifo read enable
- recon_cmd_valid  input  1  recon_cmd valid, one cycle after recon_cmd_en
- frame_idct_rd_dta_empty  input  1  idct row fifo empty
- frame_idct_rd_dta  input  72  idct row; sample 0 (leftmost) in [71:63], sample 7 in [8:0]
- frame_idct_rd_dta_en  output  1  idct fifo read enable
- frame_idct_rd_dta_valid  input  1  idct row valid, one cycle after en
- pred_rd_dta_empty  input  1  prediction fifo empty
- pred_rd_dta  input  64  prediction row; pixel 0 in [63:56]
- pred_rd_dta_en  output  1  prediction fifo read enable
- pred_rd_dta_valid  input  1  prediction row valid, one cycle after en
- recon_wr_almost_full  input  1  low guarantees room for 8 rows
- recon_wr_dta  output  64  reconstructed row; pixel 0 in [63:56]
- recon_wr_en  output  1  write strobe for recon_wr_dta
- recon_sync_error  output  1  sticky: fifo valid mismatch detected

## Operation
- States: INIT, CMD_RD_EN, CMD_READ, WAIT_DTA, DTA_RD_EN, DTA_READ.
- INIT: stay while recon_cmd_empty or recon_wr_almost_full; else go to CMD_RD_EN. Row counter cleared to 0.
- CMD_RD_EN: recon_cmd_en high for this cycle. Next state is CMD_READ.
- CMD_READ: cmd latched on recon_cmd_valid. Next state is WAIT_DTA.
- WAIT_DTA: wait until every fifo needed by cmd is non-empty. RECON_INTRA needs idct only. RECON_ADD needs idct and pred. RECON_PRED_ONLY needs pred only.
- DTA_RD_EN: assert the needed read enables together for one cycle. Next state is DTA_READ.
- DTA_READ: row counter increments. If the counter was 7, go to INIT; else go to WAIT_DTA.
- A reserved command is treated as RECON_ADD.
- Arithmetic, per sample: pred is zero-extended to 10 bits and idct is sign-extended to 10 bits.
  - INTRA: sum = idct. ADD: sum = pred + idct. PRED_ONLY: sum = pred.
  - Clip: sum < 0 gives 0; sum > 255 gives 255.
- Data is registered on the arrival of valid. If a needed valid is absent, or an unneeded valid is present, in the DTA_READ cycle, recon_sync_error sets. It stays set until reset. The row is still written using the data present.

## Timing
- Read enables and recon_cmd_en are registered from next-state decode. They are forced low when clk_en is low.
- Row throughput is 3 clk_en cycles per row (WAIT_DTA, DTA_RD_EN, DTA_READ) when fifos are non-empty.
- Per-block overhead is 3 cycles (INIT, CMD_RD_EN, CMD_READ).
- recon_wr_en rises exactly one clk_en cycle after the fifo valid.
- recon_wr_dta is held stable while recon_wr_en is high. recon_wr_en is low whenever clk_en is low.
- Reset values: recon_cmd_en, frame_idct_rd_dta_en, pred_rd_dta_en, recon_wr_en, recon_sync_error = 0; recon_wr_dta = 64'h0; state = INIT; row counter = 0.
- recon_wr_almost_full is checked only in INIT. A block, once started, completes all 8 rows.
- An empty fifo mid-block stalls in WAIT_DTA indefinitely. This causes no data loss and no partial write.
- Reset mid-block returns to INIT and discards the partial block. Rows already written are not retracted.

## Test plan
- RECON_INTRA: idct row all 9'sh07F plus sample 7 = 9'h1F0 (-16) -> recon_wr_dta = 64'h7F7F7F7F7F7F7F00. The pred fifo is never read.
- RECON_ADD: pred 64'h80 in every byte, idct samples {+127, -128, +200, -200, 0, 1, -1, 127} -> pixels {FF, 00, FF, 00, 80, 81, 7F, FF}. Exactly 8 pred and 8 idct reads.
- RECON_PRED_ONLY: 8 pred rows 64'h0123456789ABCDEF -> identical output rows. frame_idct_rd_dta_en never asserted.
- Back-pressure: recon_wr_almost_full high with a command pending -> no recon_cmd_en until it drops. Then 8 writes.
- Stall and clk_en: idct fifo empty after row 3; clk_en toggled 50% -> exactly 8 writes, in order, no duplicates.
- Sync error plus reset: force pred_rd_dta_valid low in one ADD row -> recon_sync_error = 1 and stays set. Assert rst mid-block -> all outputs 0, state returns to INIT.

Source files
------------

// File: rtl/motcomp_recon_add.sv
// rtl/motcomp_recon_add.sv - motion compensation reconstruction adder (idct + prediction, clipped)
//
// Per 8x8 block: fetch one command, then eight rows of idct residual and/or
// prediction, add them, clip each sample to 0..255 and write one 64-bit
// pixel row per input row.
//
// Ports:
//   clk, clk_en, rst           clock, clock enable (freezes all state), sync active-low reset
//   recon_cmd_*                command fifo: empty, data, read enable, valid (1 cycle after en)
//   frame_idct_rd_dta_*        idct row fifo: 8 x 9-bit signed, sample 0 in [71:63]
//   pred_rd_dta_*              prediction row fifo: 8 x 8-bit unsigned, pixel 0 in [63:56]
//   recon_wr_almost_full       low guarantees room for a whole block
//   recon_wr_dta, recon_wr_en  reconstructed row and its write strobe
//   recon_sync_error           sticky fifo-valid mismatch flag

module motcomp_recon_add (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        rst,
  input  logic        recon_cmd_empty,
  input  logic [1:0]  recon_cmd,
  output logic        recon_cmd_en,
  input  logic        recon_cmd_valid,
  input  logic        frame_idct_rd_dta_empty,
  input  logic [71:0] frame_idct_rd_dta,
  output logic        frame_idct_rd_dta_en,
  input  logic        frame_idct_rd_dta_valid,
  input  logic        pred_rd_dta_empty,
  input  logic [63:0] pred_rd_dta,
  output logic        pred_rd_dta_en,
  input  logic        pred_rd_dta_valid,
  input  logic        recon_wr_almost_full,
  output logic [63:0] recon_wr_dta,
  output logic        recon_wr_en,
  output logic        recon_sync_error
);

  localparam logic [1:0] RECON_INTRA     = 2'd0;
  localparam logic [1:0] RECON_ADD       = 2'd1;
  localparam logic [1:0] RECON_PRED_ONLY = 2'd2;

  typedef enum logic [2:0] {
    INIT,
    CMD_RD_EN,
    CMD_READ,
    WAIT_DTA,
    DTA_RD_EN,
    DTA_READ
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  row_cnt;
  logic [1:0]  cmd;
  logic        cmd_en_r;
  logic        idct_en_r;
  logic        pred_en_r;
  logic        wr_en_r;
  logic        sync_err_r;
  logic        need_idct;
  logic        need_pred;
  logic        fifos_ready;
  logic [63:0] row_sum;

  // cmd only ever holds INTRA, ADD or PRED_ONLY; reserved codes are folded
  // into ADD when latched.
  assign need_idct   = (cmd != RECON_PRED_ONLY);
  assign need_pred   = (cmd != RECON_INTRA);
  assign fifos_ready = (!need_idct || !frame_idct_rd_dta_empty) &&
                       (!need_pred || !pred_rd_dta_empty);

  // Enable registers hold across clk_en-low cycles; gating keeps the
  // strobes from being seen more than once by the clk_en-qualified fifos.
  assign recon_cmd_en         = cmd_en_r  & clk_en;
  assign frame_idct_rd_dta_en = idct_en_r & clk_en;
  assign pred_rd_dta_en       = pred_en_r & clk_en;
  assign recon_wr_en          = wr_en_r   & clk_en;
  assign recon_sync_error     = sync_err_r;

  function automatic logic [7:0] recon_pixel(input logic [1:0] c,
                                             input logic [8:0] idct,
                                             input logic [7:0] pred);
    logic signed [9:0] p;
    logic signed [9:0] i;
    logic signed [9:0] s;
    p = signed'({2'b00, pred});
    i = signed'({idct[8], idct});
    case (c)
      RECON_INTRA:     s = i;
      RECON_PRED_ONLY: s = p;
      default:         s = p + i;
    endcase
    if (s < 10'sd0)
      recon_pixel = 8'h00;
    else if (s > 10'sd255)
      recon_pixel = 8'hFF;
    else
      recon_pixel = s[7:0];
  endfunction

  always_comb begin
    row_sum = '0;
    for (int k = 0; k < 8; k++) begin
      row_sum[63-8*k -: 8] = recon_pixel(cmd,
                                         frame_idct_rd_dta[71-9*k -: 9],
                                         pred_rd_dta[63-8*k -: 8]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      if (!recon_cmd_empty && !recon_wr_almost_full) state_nxt = CMD_RD_EN;
      CMD_RD_EN: state_nxt = CMD_READ;
      CMD_READ:  state_nxt = WAIT_DTA;
      WAIT_DTA:  if (fifos_ready) state_nxt = DTA_RD_EN;
      DTA_RD_EN: state_nxt = DTA_READ;
      DTA_READ:  state_nxt = (row_cnt == 3'd7) ? INIT : WAIT_DTA;
      default:   state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= INIT;
      row_cnt      <= 3'd0;
      cmd          <= RECON_INTRA;
      cmd_en_r     <= 1'b0;
      idct_en_r    <= 1'b0;
      pred_en_r    <= 1'b0;
      wr_en_r      <= 1'b0;
      sync_err_r   <= 1'b0;
      recon_wr_dta <= 64'h0;
    end else if (clk_en) begin
      state     <= state_nxt;
      cmd_en_r  <= (state_nxt == CMD_RD_EN);
      idct_en_r <= (state_nxt == DTA_RD_EN) && need_idct;
      pred_en_r <= (state_nxt == DTA_RD_EN) && need_pred;
      wr_en_r   <= 1'b0;
      case (state)
        INIT: row_cnt <= 3'd0;
        CMD_READ: begin
          if (recon_cmd_valid)
            cmd <= (recon_cmd == 2'd3) ? RECON_ADD : recon_cmd;
        end
        DTA_READ: begin
          row_cnt      <= row_cnt + 3'd1;
          recon_wr_dta <= row_sum;
          wr_en_r      <= 1'b1;
          // A missing needed row or a stray unneeded row means the fifos
          // have slipped relative to the command stream.
          if ((need_idct != frame_idct_rd_dta_valid) ||
              (need_pred != pred_rd_dta_valid))
            sync_err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motcomp_recon_add.sv
// tb/tb_motcomp_recon_add.sv - scoreboard bench for motcomp_recon_add
module tb_motcomp_recon_add;

  logic        clk = 1'b0;
  logic        clk_en;
  logic        rst;
  logic        recon_cmd_empty;
  logic [1:0]  recon_cmd;
  logic        recon_cmd_en;
  logic        recon_cmd_valid;
  logic        frame_idct_rd_dta_empty;
  logic [71:0] frame_idct_rd_dta;
  logic        frame_idct_rd_dta_en;
  logic        frame_idct_rd_dta_valid;
  logic        pred_rd_dta_empty;
  logic [63:0] pred_rd_dta;
  logic        pred_rd_dta_en;
  logic        pred_rd_dta_valid;
  logic        recon_wr_almost_full;
  logic [63:0] recon_wr_dta;
  logic        recon_wr_en;
  logic        recon_sync_error;

  motcomp_recon_add dut (
    .clk                     (clk),
    .clk_en                  (clk_en),
    .rst                     (rst),
    .recon_cmd_empty         (recon_cmd_empty),
    .recon_cmd               (recon_cmd),
    .recon_cmd_en            (recon_cmd_en),
    .recon_cmd_valid         (recon_cmd_valid),
    .frame_idct_rd_dta_empty (frame_idct_rd_dta_empty),
    .frame_idct_rd_dta       (frame_idct_rd_dta),
    .frame_idct_rd_dta_en    (frame_idct_rd_dta_en),
    .frame_idct_rd_dta_valid (frame_idct_rd_dta_valid),
    .pred_rd_dta_empty       (pred_rd_dta_empty),
    .pred_rd_dta             (pred_rd_dta),
    .pred_rd_dta_en          (pred_rd_dta_en),
    .pred_rd_dta_valid       (pred_rd_dta_valid),
    .recon_wr_almost_full    (recon_wr_almost_full),
    .recon_wr_dta            (recon_wr_dta),
    .recon_wr_en             (recon_wr_en),
    .recon_sync_error        (recon_sync_error)
  );

  initial forever #5 clk = ~clk;

  logic [1:0]  cmd_q[$];
  logic [71:0] idct_q[$];
  logic [63:0] pred_q[$];
  logic [63:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0, cmd_en_cnt = 0, idct_en_cnt = 0, pred_en_cnt = 0;
  int idct_pop_cnt = 0, idct_pop_limit = 32'h7fffffff;
  int pred_pop_cnt = 0, pred_kill_idx = -1;
  int ce_pct = 100;
  bit ce_random = 1'b0;
  bit ce_s, cmd_fire, idct_fire, pred_fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: per-sample integer add and clamp.
  function automatic logic [63:0] model_row(input logic [1:0] c, input logic [71:0] id,
                                             input logic [63:0] pr);
    logic [63:0] r;
    int iv, pv, s;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      iv = int'(id[71-9*k -: 9]);
      if (iv > 255) iv = iv - 512;
      pv = int'(pr[63-8*k -: 8]);
      if (c == 2'd0)      s = iv;
      else if (c == 2'd2) s = pv;
      else                s = pv + iv;
      if (s < 0)   s = 0;
      if (s > 255) s = 255;
      r[63-8*k -: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic push_block(input logic [1:0] c, input bit rnd,
                            input logic [71:0] id_fix, input logic [63:0] pr_fix);
    logic [95:0] t;
    logic [71:0] id;
    logic [63:0] pr;
    cmd_q.push_back(c);
    for (int r = 0; r < 8; r++) begin
      id = id_fix;
      pr = pr_fix;
      if (rnd) begin
        t  = {$urandom(), $urandom(), $urandom()};
        id = t[71:0];
        pr = {$urandom(), $urandom()};
      end
      if (c != 2'd2) idct_q.push_back(id);
      if (c != 2'd0) pred_q.push_back(pr);
      exp_q.push_back(model_row(c, id, pr));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d rows still expected after %0d cycles", name, exp_q.size(), n);
    end
    step(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_en"},  64'(recon_cmd_en), 64'd0);
    check({tag, "_idct_en"}, 64'(frame_idct_rd_dta_en), 64'd0);
    check({tag, "_pred_en"}, 64'(pred_rd_dta_en), 64'd0);
    check({tag, "_wr_en"},   64'(recon_wr_en), 64'd0);
    check({tag, "_sync"},    64'(recon_sync_error), 64'd0);
    check({tag, "_wr_dta"},  recon_wr_dta, 64'h0);
  endtask

  // Monitor: sample outputs mid-cycle, pop scoreboard on each write.
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    ce_s      = clk_en;
    cmd_fire  = recon_cmd_en;
    idct_fire = frame_idct_rd_dta_en;
    pred_fire = pred_rd_dta_en;
    if (recon_cmd_en)         cmd_en_cnt++;
    if (frame_idct_rd_dta_en) idct_en_cnt++;
    if (pred_rd_dta_en)       pred_en_cnt++;
    if (recon_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %h expected no write", recon_wr_dta);
      end else begin
        e = exp_q.pop_front();
        check("recon_row", recon_wr_dta, e);
      end
    end
  end

  // Fifo models: a read strobe seen on a clk_en edge yields valid data for
  // the next clk_en cycle; valid holds while clk_en is low.
  initial forever begin
    @(posedge clk);
    #1;
    if (ce_s) begin
      recon_cmd_valid = 1'b0;
      if (cmd_fire && cmd_q.size() > 0) begin
        recon_cmd       = cmd_q.pop_front();
        recon_cmd_valid = 1'b1;
      end
      frame_idct_rd_dta_valid = 1'b0;
      if (idct_fire && idct_q.size() > 0 && idct_pop_cnt < idct_pop_limit) begin
        frame_idct_rd_dta       = idct_q.pop_front();
        idct_pop_cnt++;
        frame_idct_rd_dta_valid = 1'b1;
      end
      pred_rd_dta_valid = 1'b0;
      if (pred_fire && pred_q.size() > 0) begin
        pred_rd_dta       = pred_q.pop_front();
        pred_pop_cnt++;
        pred_rd_dta_valid = (pred_pop_cnt != pred_kill_idx);
      end
    end
    recon_cmd_empty         = (cmd_q.size() == 0);
    frame_idct_rd_dta_empty = (idct_q.size() == 0) || (idct_pop_cnt >= idct_pop_limit);
    pred_rd_dta_empty       = (pred_q.size() == 0);
    clk_en = ce_random ? ($urandom_range(99) < ce_pct) : 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, i0, p0, w0, n;
    logic [71:0] intra_row;
    logic [71:0] add_row;
    rst = 1'b0;
    clk_en = 1'b1;
    recon_cmd_empty = 1'b1;
    recon_cmd = 2'd0;
    recon_cmd_valid = 1'b0;
    frame_idct_rd_dta_empty = 1'b1;
    frame_idct_rd_dta = '0;
    frame_idct_rd_dta_valid = 1'b0;
    pred_rd_dta_empty = 1'b1;
    pred_rd_dta = '0;
    pred_rd_dta_valid = 1'b0;
    recon_wr_almost_full = 1'b0;

    step(3);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(2);

    // INTRA: pred fifo never read
    intra_row = {9'h07F, 9'h07F, 9'h07F, 9'h07F, 9'h07F, 9'h07F, 9'h07F, 9'h1F0};
    i0 = idct_en_cnt; p0 = pred_en_cnt;
    push_block(2'd0, 1'b0, intra_row, 64'h0);
    drain("intra", 300);
    check("intra_idct_reads", 64'(idct_en_cnt - i0), 64'd8);
    check("intra_pred_reads", 64'(pred_en_cnt - p0), 64'd0);

    // ADD with clipping at both ends
    add_row = {9'h07F, 9'h180, 9'h0C8, 9'h138, 9'h000, 9'h001, 9'h1FF, 9'h07F};
    i0 = idct_en_cnt; p0 = pred_en_cnt;
    push_block(2'd1, 1'b0, add_row, 64'h8080808080808080);
    drain("add", 300);
    check("add_idct_reads", 64'(idct_en_cnt - i0), 64'd8);
    check("add_pred_reads", 64'(pred_en_cnt - p0), 64'd8);

    // PRED_ONLY: idct fifo never read
    i0 = idct_en_cnt; p0 = pred_en_cnt;
    push_block(2'd2, 1'b0, 72'h0, 64'h0123456789ABCDEF);
    drain("pred_only", 300);
    check("pred_only_idct_reads", 64'(idct_en_cnt - i0), 64'd0);
    check("pred_only_pred_reads", 64'(pred_en_cnt - p0), 64'd8);

    // Back-pressure: no command read while almost_full
    recon_wr_almost_full = 1'b1;
    c0 = cmd_en_cnt; w0 = wr_cnt;
    push_block(2'd1, 1'b1, 72'h0, 64'h0);
    step(30);
    check("bp_cmd_reads", 64'(cmd_en_cnt - c0), 64'd0);
    check("bp_writes", 64'(wr_cnt - w0), 64'd0);
    recon_wr_almost_full = 1'b0;
    drain("backpressure", 300);
    check("bp_writes_after", 64'(wr_cnt - w0), 64'd8);

    // Stall after 3 idct rows with clk_en toggling
    ce_random = 1'b1; ce_pct = 50;
    w0 = wr_cnt;
    idct_pop_limit = idct_pop_cnt + 3;
    push_block(2'd1, 1'b1, 72'h0, 64'h0);
    step(120);
    check("stall_writes", 64'(wr_cnt - w0), 64'd3);
    idct_pop_limit = 32'h7fffffff;
    drain("stall", 1000);
    check("stall_writes_after", 64'(wr_cnt - w0), 64'd8);

    // Random blocks, including the reserved command code
    ce_pct = 75;
    for (int b = 0; b < 24; b++) begin
      push_block(2'($urandom_range(3)), 1'b1, 72'h0, 64'h0);
    end
    drain("random", 5000);
    check("random_no_sync_err", 64'(recon_sync_error), 64'd0);
    ce_random = 1'b0;

    // Sync error: drop pred valid on one ADD row; flag is sticky
    pred_kill_idx = pred_pop_cnt + 3;
    push_block(2'd1, 1'b1, 72'h0, 64'h0);
    drain("sync", 300);
    check("sync_err_set", 64'(recon_sync_error), 64'd1);
    pred_kill_idx = -1;
    push_block(2'd0, 1'b1, 72'h0, 64'h0);
    drain("sync_sticky", 300);
    check("sync_err_sticky", 64'(recon_sync_error), 64'd1);

    // Reset mid-block
    w0 = wr_cnt; n = 0;
    push_block(2'd1, 1'b1, 72'h0, 64'h0);
    while ((wr_cnt - w0) < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midblock_reached", 64'((wr_cnt - w0) >= 3), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(2);
    cmd_q.delete(); idct_q.delete(); pred_q.delete();
    recon_cmd_valid = 1'b0; frame_idct_rd_dta_valid = 1'b0; pred_rd_dta_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    rst = 1'b1;
    step(2);
    w0 = wr_cnt;
    push_block(2'd0, 1'b1, 72'h0, 64'h0);
    drain("after_reset", 300);
    check("after_reset_writes", 64'(wr_cnt - w0), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
